// File: rtl/dev_tx_cmd_pkg.sv
// dev_tx_cmd_pkg: shared FSM encodings and command word layout for the TX/RX command readers.
package dev_tx_cmd_pkg;
    typedef enum logic [4:0] {
        S_IDLE = 5'b00001,
        S_W1   = 5'b00010,
        S_CALC = 5'b00100,
        S_REQ  = 5'b01000,
        S_DONE = 5'b10000
    } state_e;
    localparam int TAG_MSB = 29;
    localparam int TAG_LSB = 26;
    localparam int PAGE_DW = 1024;
endpackage

// File: rtl/dev_tx_seg_calc.sv
// dev_tx_seg_calc: segment length = min(remaining, max payload, DWs left in the 4 KB page).
module dev_tx_seg_calc
    import dev_tx_cmd_pkg::*;
#(
    parameter int P_MAX_PAYLOAD_DW = 32,
    parameter int P_LEN_WIDTH      = 12
) (
    input  logic [9:0]             addr_lo_i,
    input  logic [P_LEN_WIDTH-1:0] rem_i,
    output logic [10:0]            seg_o
);
    localparam int W = P_LEN_WIDTH > 11 ? P_LEN_WIDTH : 11;
    typedef logic [W-1:0] cmp_t;
    cmp_t page_left, max_pl, rem_w, m0, m1;
    always_comb begin
        page_left = cmp_t'(11'(PAGE_DW) - {1'b0, addr_lo_i});
        max_pl    = cmp_t'(P_MAX_PAYLOAD_DW);
        rem_w     = cmp_t'(rem_i);
        m0        = rem_w < max_pl ? rem_w : max_pl;
        m1        = m0 < page_left ? m0 : page_left;
        seg_o     = m1[10:0];
    end
endmodule

// File: rtl/dev_tx_cmd_reader.sv
// dev_tx_cmd_reader: pops two-word DMA write commands and issues them as PCIe-legal segments.
module dev_tx_cmd_reader
    import dev_tx_cmd_pkg::*;
#(
    parameter int P_FIFO_DATA_WIDTH = 30,
    parameter int P_MAX_PAYLOAD_DW  = 32,
    parameter int P_LEN_WIDTH       = 12
) (
    input  logic                         pcie_user_clk,
    input  logic                         pcie_user_rst_n,
    output logic                         tx_cmd_rd_en,
    input  logic [P_FIFO_DATA_WIDTH-1:0] tx_cmd_rd_data,
    input  logic                         tx_cmd_empty_n,
    output logic                         tx_dma_req,
    input  logic                         tx_dma_req_ack,
    output logic [29:0]                  tx_dma_addr,
    output logic [10:0]                  tx_dma_len,
    output logic                         tx_cmd_done,
    output logic [3:0]                   tx_cmd_done_tag,
    output logic                         tx_cmd_err
);
    typedef logic [P_LEN_WIDTH-1:0] len_t;
    state_e      state_q, state_d;
    logic [29:0] addr_q, addr_d;
    len_t        rem_q, rem_d;
    logic [3:0]  tag_q, tag_d;
    logic [10:0] seg_q, seg_d, seg_w;
    logic        err_q, err_d, pop;
    dev_tx_seg_calc #(
        .P_MAX_PAYLOAD_DW(P_MAX_PAYLOAD_DW),
        .P_LEN_WIDTH     (P_LEN_WIDTH)
    ) u_seg (
        .addr_lo_i(addr_q[9:0]),
        .rem_i    (rem_q),
        .seg_o    (seg_w)
    );
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        tag_d   = tag_q;
        seg_d   = seg_q;
        err_d   = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: if (tx_cmd_empty_n) begin
                pop     = 1'b1;
                addr_d  = tx_cmd_rd_data[29:0];
                state_d = S_W1;
            end
            S_W1: if (tx_cmd_empty_n) begin
                pop     = 1'b1;
                tag_d   = tx_cmd_rd_data[TAG_MSB:TAG_LSB];
                rem_d   = tx_cmd_rd_data[P_LEN_WIDTH-1:0];
                err_d   = tx_cmd_rd_data[P_LEN_WIDTH-1:0] == '0;
                state_d = err_d ? S_IDLE : S_CALC;
            end
            S_CALC: begin
                seg_d   = seg_w;
                state_d = S_REQ;
            end
            S_REQ: if (tx_dma_req_ack) begin
                addr_d  = addr_q + 30'(seg_q);
                rem_d   = rem_q - len_t'(seg_q);
                state_d = rem_q == len_t'(seg_q) ? S_DONE : S_CALC;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
        if (!pcie_user_rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            tag_q   <= '0;
            seg_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            tag_q   <= tag_d;
            seg_q   <= seg_d;
            err_q   <= err_d;
        end
    end
    // Gate the pop with reset so a held reset never drains the FIFO.
    assign tx_cmd_rd_en    = pop & pcie_user_rst_n;
    assign tx_dma_req      = state_q == S_REQ;
    assign tx_dma_addr     = addr_q;
    assign tx_dma_len      = seg_q;
    assign tx_cmd_done     = state_q == S_DONE;
    assign tx_cmd_done_tag = tag_q;
    assign tx_cmd_err      = err_q;
endmodule

// File: tb/tb_dev_tx_cmd_reader.sv
// tb_dev_tx_cmd_reader: scoreboard bench with a FIFO model and a TX engine with programmable ack delay.
module tb_dev_tx_cmd_reader;
    logic        pcie_user_clk = 1'b0;
    logic        pcie_user_rst_n = 1'b0;
    logic        tx_cmd_rd_en;
    logic [29:0] tx_cmd_rd_data = '0;
    logic        tx_cmd_empty_n = 1'b0;
    logic        tx_dma_req;
    logic        tx_dma_req_ack = 1'b0;
    logic [29:0] tx_dma_addr;
    logic [10:0] tx_dma_len;
    logic        tx_cmd_done;
    logic [3:0]  tx_cmd_done_tag;
    logic        tx_cmd_err;
    typedef struct {
        logic [29:0] addr;
        logic [10:0] len;
    } seg_t;
    seg_t        exp_seg[$];
    logic [3:0]  exp_tag[$];
    logic [29:0] fifo[$];
    int n_vec = 0, n_bad = 0, n_done = 0, n_err = 0, pops = 0, cyc = 0;
    int ack_delay = 0, last_req_cyc = 0, last_done_cyc = 0;
    always #5 pcie_user_clk = ~pcie_user_clk;
    always @(posedge pcie_user_clk) cyc <= cyc + 1;
    dev_tx_cmd_reader dut (
        .pcie_user_clk  (pcie_user_clk),
        .pcie_user_rst_n(pcie_user_rst_n),
        .tx_cmd_rd_en   (tx_cmd_rd_en),
        .tx_cmd_rd_data (tx_cmd_rd_data),
        .tx_cmd_empty_n (tx_cmd_empty_n),
        .tx_dma_req     (tx_dma_req),
        .tx_dma_req_ack (tx_dma_req_ack),
        .tx_dma_addr    (tx_dma_addr),
        .tx_dma_len     (tx_dma_len),
        .tx_cmd_done    (tx_cmd_done),
        .tx_cmd_done_tag(tx_cmd_done_tag),
        .tx_cmd_err     (tx_cmd_err)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask
    task automatic refresh();
        tx_cmd_empty_n = fifo.size() != 0;
        tx_cmd_rd_data = fifo.size() != 0 ? fifo[0] : '0;
    endtask
    task automatic tick();
        logic p;
        @(negedge pcie_user_clk);
        p = tx_cmd_rd_en;
        @(posedge pcie_user_clk);
        #1;
        if (p && fifo.size() != 0) begin
            void'(fifo.pop_front());
            pops++;
        end
        refresh();
    endtask
    // Reference splitter: walk the command, clipping by payload and by page end.
    task automatic expect_cmd(input logic [29:0] a, input int len, input logic [3:0] tag);
        int   r;
        int   s;
        seg_t e;
        r = len;
        while (r > 0) begin
            s = r;
            if (s > 32) s = 32;
            if (s > 1024 - int'(a[9:0])) s = 1024 - int'(a[9:0]);
            e.addr = a;
            e.len  = 11'(s);
            exp_seg.push_back(e);
            a = a + 30'(s);
            r -= s;
        end
        if (len > 0) exp_tag.push_back(tag);
    endtask
    task automatic push_w0(input logic [31:0] byte_addr);
        fifo.push_back(byte_addr[31:2]);
        refresh();
    endtask
    task automatic push_w1(input logic [3:0] tag, input int len);
        fifo.push_back({tag, 14'($urandom), 12'(len)});
        refresh();
    endtask
    task automatic send(input logic [31:0] byte_addr, input int len, input logic [3:0] tag);
        expect_cmd(byte_addr[31:2], len, tag);
        push_w0(byte_addr);
        push_w1(tag, len);
    endtask
    task automatic wait_done(input int target, input string tag);
        int n;
        n = 0;
        while (n_done < target && n < 600) begin
            tick();
            n++;
        end
        chk(tag, 32'(n_done), 32'(target));
    endtask
    // TX engine: checks each new segment, holds ack off for ack_delay cycles, then acks once.
    initial begin
        seg_t        e;
        logic [29:0] a;
        logic [10:0] l;
        logic        ab;
        forever begin
            @(negedge pcie_user_clk);
            if (pcie_user_rst_n && tx_dma_req) begin
                last_req_cyc = cyc;
                if (exp_seg.size() == 0) chk("spurious_req", 32'(tx_dma_req), 0);
                else begin
                    e = exp_seg.pop_front();
                    chk("seg_addr", 32'(tx_dma_addr), 32'(e.addr));
                    chk("seg_len", 32'(tx_dma_len), 32'(e.len));
                end
                a  = tx_dma_addr;
                l  = tx_dma_len;
                ab = 1'b0;
                for (int i = 0; i < ack_delay && !ab; i++) begin
                    @(negedge pcie_user_clk);
                    if (!pcie_user_rst_n) ab = 1'b1;
                    else begin
                        chk("hold_req", 32'(tx_dma_req), 1);
                        chk("hold_addr", 32'(tx_dma_addr), 32'(a));
                        chk("hold_len", 32'(tx_dma_len), 32'(l));
                        chk("no_pop_busy", 32'(tx_cmd_rd_en), 0);
                    end
                end
                if (!ab) begin
                    @(posedge pcie_user_clk);
                    #1 tx_dma_req_ack = 1'b1;
                    @(posedge pcie_user_clk);
                    #1 tx_dma_req_ack = 1'b0;
                    @(negedge pcie_user_clk);
                    chk("req_drop", 32'(tx_dma_req), 0);
                end
            end
        end
    end
    initial begin
        forever begin
            @(negedge pcie_user_clk);
            if (tx_cmd_done) begin
                n_done++;
                last_done_cyc = cyc;
                if (exp_tag.size() == 0) chk("spurious_done", 32'(tx_cmd_done), 0);
                else chk("done_tag", 32'(tx_cmd_done_tag), 32'(exp_tag.pop_front()));
            end
            if (tx_cmd_err) n_err++;
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end
    initial begin
        int t0, p0, d0, e0, n;
        repeat (3) @(posedge pcie_user_clk);
        #1;
        chk("rst_req", 32'(tx_dma_req), 0);
        chk("rst_addr", 32'(tx_dma_addr), 0);
        chk("rst_len", 32'(tx_dma_len), 0);
        chk("rst_done", 32'(tx_cmd_done), 0);
        chk("rst_tag", 32'(tx_cmd_done_tag), 0);
        chk("rst_err", 32'(tx_cmd_err), 0);
        send(32'h0000_1000, 16, 4'd3);
        #1;
        chk("rst_rd_en", 32'(tx_cmd_rd_en), 0);
        @(posedge pcie_user_clk);
        #1 pcie_user_rst_n = 1'b1;
        t0 = cyc;
        wait_done(1, "t1_done");
        chk("t1_req_lat", 32'(last_req_cyc - t0), 3);
        chk("t1_done_lat", 32'(last_done_cyc - t0), 5);
        send(32'h0000_0000, 100, 4'd7);
        wait_done(2, "t2_done");
        send(32'h0000_0FF0, 40, 4'd9);
        wait_done(3, "t3_done");
        ack_delay = 7;
        p0 = pops;
        send(32'h0000_2000, 8, 4'd1);
        send(32'h0000_3000, 4, 4'd2);
        wait_done(5, "t4_done");
        chk("t4_pops", 32'(pops - p0), 4);
        ack_delay = 0;
        e0 = n_err;
        send(32'h0000_4000, 0, 4'd5);
        send(32'h0000_4100, 3, 4'd6);
        wait_done(6, "t5_done");
        chk("t5_err", 32'(n_err - e0), 1);
        p0 = pops;
        expect_cmd(30'h0000_1800, 12, 4'd10);
        push_w0(32'h0000_6000);
        repeat (20) tick();
        chk("w1_pops", 32'(pops - p0), 1);
        chk("w1_req", 32'(tx_dma_req), 0);
        push_w1(4'd10, 12);
        wait_done(7, "t6_done");
        ack_delay = 50;
        send(32'h0000_5000, 100, 4'd4);
        n = 0;
        while (!tx_dma_req && n < 20) begin
            tick();
            n++;
        end
        chk("t7_req_seen", 32'(tx_dma_req), 1);
        repeat (3) tick();
        p0 = pops;
        d0 = n_done;
        push_w0(32'h0000_7000);
        pcie_user_rst_n = 1'b0;
        #1;
        chk("t7_rd_en", 32'(tx_cmd_rd_en), 0);
        chk("t7_req", 32'(tx_dma_req), 0);
        chk("t7_addr", 32'(tx_dma_addr), 0);
        chk("t7_len", 32'(tx_dma_len), 0);
        chk("t7_done", 32'(tx_cmd_done), 0);
        chk("t7_tag", 32'(tx_cmd_done_tag), 0);
        exp_seg.delete();
        exp_tag.delete();
        repeat (2) tick();
        chk("t7_no_pop", 32'(pops - p0), 0);
        fifo.delete();
        refresh();
        ack_delay = 0;
        pcie_user_rst_n = 1'b1;
        tick();
        chk("t7_no_done", 32'(n_done - d0), 0);
        chk("t7_idle_req", 32'(tx_dma_req), 0);
        send(32'hFFFF_FFF8, 6, 4'd11);
        wait_done(d0 + 1, "t8_done");
        repeat (3) tick();
        chk("seg_q_empty", 32'(exp_seg.size()), 0);
        chk("tag_q_empty", 32'(exp_tag.size()), 0);
        chk("err_total", 32'(n_err), 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
